// File: rtl/servo_pwm_decoder.sv
// servo_pwm_decoder: measures servo PWM width/period in us and
// decodes the width back into a 0..180 degree angle.
module servo_pwm_decoder #(
  parameter int CLK_PER_US   = 50,
  parameter int MIN_PULSE_US = 500,
  parameter int MAX_PULSE_US = 2500,
  parameter int TIMEOUT_US   = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pwm_in,
  output logic        valid,
  output logic [15:0] pulse_us,
  output logic [15:0] period_us,
  output logic [7:0]  angle,
  output logic        err_range,
  output logic        signal_lost
);

  localparam int PSW =
    (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PSW-1:0] PS_LAST =
    PSW'(CLK_PER_US - 1);
  localparam logic [15:0] MIN_W = 16'(MIN_PULSE_US);
  localparam logic [15:0] MAX_W = 16'(MAX_PULSE_US);
  localparam logic [15:0] TO_LAST =
    16'(TIMEOUT_US - 1);
  localparam logic [23:0] DIV_D =
    24'(MAX_PULSE_US - MIN_PULSE_US);

  typedef enum logic [1:0] {
    WAIT_RISE,
    HIGH,
    LOW
  } meas_t;

  typedef enum logic {
    IDLE,
    DIV
  } dstate_t;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v,
    input logic        t
  );
    if (t && (v != 16'hFFFF)) return v + 16'd1;
    return v;
  endfunction

  logic           r_s1, r_s2, r_s3;
  logic [1:0]     r_warm;
  logic           r_rise, r_fall;
  logic           w_edge;
  logic [PSW-1:0] r_presc;
  logic           w_tick;
  logic [15:0]    r_width, r_per, r_idle;
  logic [15:0]    w_width_n, w_per_n, w_idle_n;
  logic           w_timeout;
  meas_t          r_state, w_state_n;
  logic           w_load, w_restart, w_per_upd;
  dstate_t        r_dstate, w_dstate_n;
  logic           w_sub, w_done, w_emit;
  logic [23:0]    r_num;
  logic [7:0]     r_q;
  logic [15:0]    r_raw;
  logic           r_fin;
  logic [15:0]    w_wc;
  logic [23:0]    w_off, w_num0;
  logic           r_valid, r_err, r_lost;
  logic [15:0]    r_pulse, r_period;
  logic [7:0]     r_angle;

  assign w_edge    = r_rise | r_fall;
  assign w_tick    = (r_presc == PS_LAST);
  assign w_width_n = sat_inc(r_width, w_tick);
  assign w_per_n   = sat_inc(r_per, w_tick);
  assign w_idle_n  = sat_inc(r_idle, w_tick);
  assign w_timeout =
    !w_edge && w_tick && (r_idle == TO_LAST);

  assign w_wc =
    (w_width_n < MIN_W) ? MIN_W :
    (w_width_n > MAX_W) ? MAX_W : w_width_n;
  assign w_off  = {8'd0, w_wc - MIN_W};
  assign w_num0 = w_off * 24'd180;
  assign w_emit = r_fin & ~w_load;

  // Synchronise pwm_in; edges are ignored until the
  // pipeline has refilled after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      r_warm <= 2'd0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_s1   <= pwm_in;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      if (r_warm != 2'd3) r_warm <= r_warm + 2'd1;
      r_rise <= (r_warm == 2'd3) & r_s2 & ~r_s3;
      r_fall <= (r_warm == 2'd3) & ~r_s2 & r_s3;
    end
  end

  // Microsecond prescaler, re-phased on every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (w_edge || w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Measurement FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= WAIT_RISE;
    else        r_state <= w_state_n;
  end

  // Measurement FSM next state and control strobes.
  always_comb begin
    w_state_n = r_state;
    w_load    = 1'b0;
    w_restart = 1'b0;
    w_per_upd = 1'b0;
    if (w_timeout) begin
      w_state_n = WAIT_RISE;
    end else begin
      unique case (r_state)
        WAIT_RISE: begin
          if (r_rise) begin
            w_state_n = HIGH;
            w_restart = 1'b1;
          end
        end
        HIGH: begin
          if (r_fall) begin
            w_state_n = LOW;
            w_load    = 1'b1;
          end
        end
        LOW: begin
          if (r_rise) begin
            w_state_n = HIGH;
            w_restart = 1'b1;
            w_per_upd = 1'b1;
          end
        end
        default: w_state_n = WAIT_RISE;
      endcase
    end
  end

  // Width, period and idle counters in us ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_width <= '0;
      r_per   <= '0;
      r_idle  <= '0;
    end else begin
      if (w_restart)
        r_width <= '0;
      else if (r_state == HIGH)
        r_width <= w_width_n;
      r_per  <= w_restart ? 16'd0 : w_per_n;
      r_idle <= w_edge ? 16'd0 : w_idle_n;
    end
  end

  // Divider FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_dstate <= IDLE;
    else        r_dstate <= w_dstate_n;
  end

  // Divider next state: one subtraction per cycle.
  always_comb begin
    w_dstate_n = r_dstate;
    w_sub      = 1'b0;
    w_done     = 1'b0;
    if (w_load) begin
      w_dstate_n = DIV;
    end else begin
      unique case (r_dstate)
        IDLE: w_dstate_n = IDLE;
        DIV: begin
          if (r_num >= DIV_D) begin
            w_sub = 1'b1;
          end else begin
            w_done     = 1'b1;
            w_dstate_n = IDLE;
          end
        end
        default: w_dstate_n = IDLE;
      endcase
    end
  end

  // Divider operands; a new width restarts the divide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num <= '0;
      r_q   <= '0;
      r_raw <= '0;
      r_fin <= 1'b0;
    end else begin
      if (w_load) begin
        r_num <= w_num0;
        r_q   <= '0;
        r_raw <= w_width_n;
      end else if (w_sub) begin
        r_num <= r_num - DIV_D;
        r_q   <= r_q + 8'd1;
      end
      r_fin <= w_done;
    end
  end

  // Result registers and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_pulse  <= '0;
      r_period <= '0;
      r_angle  <= '0;
      r_err    <= 1'b0;
      r_lost   <= 1'b1;
    end else begin
      r_valid <= w_emit;
      if (w_emit) begin
        r_angle <= r_q;
        r_pulse <= r_raw;
        r_err   <= (r_raw < MIN_W) || (r_raw > MAX_W);
      end
      if (w_emit)
        r_lost <= 1'b0;
      else if (w_timeout)
        r_lost <= 1'b1;
      if (w_per_upd)
        r_period <= w_per_n;
    end
  end

  assign valid       = r_valid;
  assign pulse_us    = r_pulse;
  assign period_us   = r_period;
  assign angle       = r_angle;
  assign err_range   = r_err;
  assign signal_lost = r_lost;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// tb_servo_pwm_decoder: directed PWM stimulus, timing-level
// model of the decoder and per-cycle output comparison.
module tb_servo_pwm_decoder;

  localparam int CPU  = 4;
  localparam int MINU = 50;
  localparam int MAXU = 250;
  localparam int TOU  = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pwm_in = 1'b0;
  logic        valid;
  logic [15:0] pulse_us;
  logic [15:0] period_us;
  logic [7:0]  angle;
  logic        err_range;
  logic        signal_lost;

  servo_pwm_decoder #(
    .CLK_PER_US  (CPU),
    .MIN_PULSE_US(MINU),
    .MAX_PULSE_US(MAXU),
    .TIMEOUT_US  (TOU)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwm_in     (pwm_in),
    .valid      (valid),
    .pulse_us   (pulse_us),
    .period_us  (period_us),
    .angle      (angle),
    .err_range  (err_range),
    .signal_lost(signal_lost)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // expectations scheduled by the driver
  int exp_vcyc = -1;
  int exp_p = 0, exp_a = 0, exp_e = 0;
  int exp_pcyc = -1, exp_pval = 0;
  int exp_lcyc = -1;
  int lit_id = 0;
  int lit_p = 0, lit_a = 0, lit_e = 0;
  int lit_per = -1, lit_tol = 0;

  // driver-side view of the line
  bit   armed = 1'b0;
  int   last_d = 0, rise_d = 0, acc = 0;
  logic cur = 1'b0;

  // model outputs and compare state
  int m_pulse = 0, m_period = 0, m_angle = 0;
  int m_err = 0, m_lost = 1;
  int lit_done = 0;

  function automatic int ang(input int w);
    if (w <= MINU) return 0;
    if (w >= MAXU) return 180;
    return (w - MINU) * 180 / (MAXU - MINU);
  endfunction

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic chk(input string nm, input int got,
                     input int want, input int tol);
    n_checks++;
    if (got < want - tol || got > want + tol) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d tol=%0d",
               nm, cyc, got, want, tol);
    end
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    bit vexp;
    vexp = 1'b0;
    if (!rst_n) begin
      m_pulse = 0; m_period = 0; m_angle = 0;
      m_err = 0; m_lost = 1;
    end else begin
      if (cyc == exp_lcyc) m_lost = 1;
      if (cyc == exp_pcyc) m_period = exp_pval;
      if (cyc == exp_vcyc) begin
        vexp = 1'b1;
        m_pulse = exp_p; m_angle = exp_a;
        m_err = exp_e; m_lost = 0;
      end
    end
    chk("valid", int'(valid), int'(vexp), 0);
    chk("pulse_us", int'(pulse_us), m_pulse, 0);
    chk("period_us", int'(period_us), m_period, 0);
    chk("angle", int'(angle), m_angle, 0);
    chk("err_range", int'(err_range), m_err, 0);
    chk("signal_lost", int'(signal_lost), m_lost, 0);
    if (valid && rst_n && lit_id != lit_done) begin
      chk("lit_pulse", int'(pulse_us), lit_p, lit_tol);
      chk("lit_angle", int'(angle), lit_a, lit_tol);
      chk("lit_err", int'(err_range), lit_e, 0);
      if (lit_per >= 0)
        chk("lit_period", int'(period_us), lit_per, 0);
      lit_done = lit_id;
    end
  end

  task automatic lit(input int p, input int a, input int e,
                     input int per, input int tol);
    lit_p = p; lit_a = a; lit_e = e;
    lit_per = per; lit_tol = tol;
    lit_id++;
  endtask

  // hold pwm_in at lvl for n cycles, scheduling model events
  task automatic seg(input logic lvl, input int n,
                     input int jit);
    int d, h, p;
    if (lvl !== cur) begin
      d = cyc + 1 + 3;
      if (d > last_d + TOU * CPU) armed = 1'b0;
      if (lvl) begin
        if (armed) begin
          p = acc + (d - last_d) / CPU;
          exp_pval = sat16(p);
          exp_pcyc = d;
        end
        acc = 0; rise_d = d; armed = 1'b1;
      end else if (armed) begin
        h = (d - rise_d) / CPU;
        acc = h;
        exp_p = sat16(h);
        exp_a = ang(h);
        exp_e = (h < MINU || h > MAXU) ? 1 : 0;
        exp_vcyc = d + exp_a + 2;
      end
      last_d = d;
      exp_lcyc = d + TOU * CPU;
      cur = lvl;
    end
    if (jit > 0) #(jit);
    pwm_in = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    exp_vcyc = -1; exp_pcyc = -1; exp_lcyc = -1;
    armed = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
    last_d = cyc;
  endtask

  // pulse of hi_us within a period of per_us
  task automatic pulse(input int hi_us, input int per_us);
    seg(1'b1, hi_us * CPU, 0);
    seg(1'b0, (per_us - hi_us) * CPU, 0);
  endtask

  initial begin
    do_reset(5);
    seg(1'b0, 20, 0);

    // nominal centre pulses
    lit(150, 90, 0, 0, 0);
    pulse(150, 400);
    lit(150, 90, 0, 400, 0);
    pulse(150, 400);
    lit(150, 90, 0, 400, 0);
    pulse(150, 400);

    // end points and a quarter
    lit(50, 0, 0, 400, 0);
    pulse(50, 400);
    lit(250, 180, 0, 400, 0);
    pulse(250, 400);
    lit(100, 45, 0, 400, 0);
    pulse(100, 400);

    // out of range both sides, then back in range
    lit(300, 180, 1, 400, 0);
    pulse(300, 400);
    lit(30, 0, 1, 400, 0);
    pulse(30, 400);
    lit(150, 90, 0, 400, 0);
    seg(1'b1, 600, 0);

    // stuck low until timeout, then restart
    seg(1'b0, TOU * CPU + 400, 0);
    lit(150, 90, 0, 400, 0);
    pulse(150, 300);
    lit(100, 45, 0, 300, 0);
    pulse(100, 300);

    // stuck high until timeout, then restart
    seg(1'b1, TOU * CPU + 400, 0);
    seg(1'b0, 600, 0);
    lit(250, 180, 0, -1, 0);
    pulse(250, 400);
    lit(50, 0, 0, 400, 0);
    pulse(50, 400);

    // reset in the middle of a high pulse
    seg(1'b1, 200, 0);
    do_reset(5);
    seg(1'b1, 200, 0);
    seg(1'b0, 600, 0);
    lit(100, 45, 0, -1, 0);
    pulse(100, 400);
    lit(150, 90, 0, 400, 0);
    pulse(150, 400);

    // edges jittered within and across clock cycles
    for (int i = 0; i < 6; i++) begin
      lit(100, 45, 0, -1, 1);
      seg(1'b1, 400 + $urandom_range(0, 2) - 1,
          $urandom_range(0, 6));
      seg(1'b0, 800 + $urandom_range(0, 2) - 1,
          $urandom_range(0, 6));
    end
    seg(1'b0, 300, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/servo_pwm_decoder.md
Name: servo_pwm_decoder

Overview:
- Receive end of the servo PWM interface that arm_model drives on pwm1/pwm2/catch_pwm.
- Measures the high-pulse width and the period of one servo PWM input, in microseconds.
- Converts the width back into a commanded angle in degrees.
- Flags out-of-range pulses and loss of signal.
- Used as closed-loop check / feedback monitor beside the arm controller; one instance per servo line.

Parameters:
- CLK_PER_US, 50, clk cycles per microsecond (50 MHz system clock).
- MIN_PULSE_US, 500, pulse width mapped to 0 degrees.
- MAX_PULSE_US, 2500, pulse width mapped to 180 degrees.
- TIMEOUT_US, 50000, microseconds without any pwm_in edge before signal_lost.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- pwm_in  input  1  asynchronous servo PWM line.
- valid  output  1  one-cycle strobe: pulse_us/angle/err_range updated this cycle.
- pulse_us  output  16  last measured high width in us; saturates at 65535.
- period_us  output  16  last rising-to-rising interval in us; saturates at 65535.
- angle  output  8  decoded angle, 0..180 degrees.
- err_range  output  1  last pulse outside [MIN_PULSE_US, MAX_PULSE_US].
- signal_lost  output  1  no edge for TIMEOUT_US.

Behaviour:
- Reset values: valid=0, pulse_us=0, period_us=0, angle=0, err_range=0, signal_lost=1. All internal counters=0, FSM=WAIT_RISE.
- Reset is honoured at any time; it aborts any measurement or divide in progress and produces no valid.
- Input sync: 2-FF synchroniser followed by a registered edge detector. An edge on pwm_in sampled at clk k is seen by the FSM in cycle k+3.
- us tick: prescaler counts 0..CLK_PER_US-1 and ticks on wrap. The prescaler restarts at 0 on every detected edge, so measurements are ±1 us.
- Width counter counts ticks while high. Period counter counts ticks from one rising edge to the next. Both saturate at 65535 and clear on the edge that starts them.
- Measurement FSM:
  - WAIT_RISE: ignore level until the first rising edge -> HIGH. This discards a partial pulse after reset.
  - HIGH: count width. Falling edge -> latch width and start the divider, go LOW.
  - LOW: count period. Rising edge -> period_us <= period count (only if a previous rising edge exists), restart counters, go HIGH.
  - A rising edge while the divider is still busy is allowed; measurement continues independently.
- Angle divider (separate FSM IDLE/DIV):
  - Clamp: w = latched width clamped to [MIN,MAX].
  - Numerator N = (w-MIN)*180, 24 bits. Divisor D = MAX-MIN.
  - Restoring by repeated subtraction, one subtraction per cycle; quotient Q = floor(N/D), remainder discarded.
  - Takes Q+1 cycles in DIV. Next cycle: angle<=Q, pulse_us<=raw (unclamped) width, err_range<=(raw<MIN or raw>MAX), valid=1 for one cycle.
  - Falling edge at clk k gives valid at cycle k+3+Q+2.
  - If a new falling edge arrives while DIV is busy (pulse shorter than ~4 us), the new width overwrites the operands and the divide restarts; only one valid is emitted.
- signal_lost:
  - Idle counter of us ticks since the last edge of either polarity.
  - Reaching TIMEOUT_US sets signal_lost=1 and returns the FSM to WAIT_RISE; the period reference is invalidated.
  - signal_lost is cleared in the cycle valid is asserted.
  - A line stuck high or stuck low both time out.
- angle and err_range hold their last value between valid strobes and across signal_lost.

Test Plan:
- Reset, then 1500 us high / 20000 us period PWM, 3 periods -> first valid: pulse_us=1500±1, angle=90, err_range=0, signal_lost 1->0. After the second rising edge period_us=20000±1.
- 500 us pulse -> angle=0. 2500 us pulse -> angle=180. 1000 us pulse -> angle=45. Each valid lands exactly 3+Q+2 cycles after the falling edge.
- 3000 us pulse -> pulse_us=3000, angle=180, err_range=1. 300 us pulse -> pulse_us=300, angle=0, err_range=1. Next 1500 us pulse clears err_range.
- Stop PWM low after a valid -> signal_lost=1 at 50000±1 us after the last edge, angle unchanged, no valid. Restart PWM: the first valid clears signal_lost and period_us is not updated until the second rising edge.
- Assert rst_n low mid-high-pulse and release -> all outputs at reset values. The partial pulse in progress produces no valid; the first full pulse decodes correctly.
- pwm_in toggling asynchronously to clk with metastability jitter on edges -> pulse_us within ±1 us of nominal and no spurious valid strobes.
